mem_access_ctrl: RTL and testbench

//  Memory-stage data-memory controller for the Y86-64 pipeline. Sits between the M pipe register and
//  the writeback stage: decodes M_icode, runs a multi-cycle req/ack transaction to data memory, and

---
 rtl/y86_pkg.sv | 40 ++++
 rtl/wait_timer.sv | 32 +++
 rtl/mem_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, memory-stage FSM states and the data-memory access payload.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {IDLE, REQ, DONE} memState_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} memOp_t;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } memAccess_t;

    // Which kind of data-memory access an instruction makes in the M stage.
    function automatic memOp_t decodeOp(input logic [3:0] icode);
        case (icode)
            ICODE_MRMOVQ, ICODE_POPQ, ICODE_RET:   decodeOp = OP_READ;
            ICODE_RMMOVQ, ICODE_PUSHQ, ICODE_CALL: decodeOp = OP_WRITE;
            default:                               decodeOp = OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Cycle counter for memory wait states; expired goes high on the cycle the count equals TIMEOUT.
module wait_timer #(
    parameter int unsigned TMR_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMR_W-1:0] count;
    logic [TMR_W-1:0] countInc;

    assign countInc = count + TMR_W'(1);

    // expired is registered alongside the count so it lines up with count==TIMEOUT
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= (TIMEOUT == 0);
        end else if (enable) begin
            count   <= countInc;
            expired <= (countInc == TMR_W'(TIMEOUT));
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Y86-64 memory-stage controller: decodes M_icode, runs a req/ack data-memory access and
// returns m_valM/m_stat to writeback, stalling the pipe through m_busy_o while it waits.
module mem_access_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TMR_W     = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  M_icode_i,
    input  logic [2:0]  M_stat_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] M_valA_i,
    input  logic        M_stall_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic [63:0] m_valM_o,
    output logic [2:0]  m_stat_o,
    output logic        m_busy_o
);

    memState_t   state;
    memOp_t      op;
    memAccess_t  acc;
    memAccess_t  nextAcc;
    logic [64:0] endAddr;
    logic        inRange;
    logic        isMemOk;
    logic        startAcc;
    logic        inReq;
    logic        timerExpired;
    logic        memReq;
    logic [63:0] valM;
    logic [2:0]  statReg;

    assign op = decodeOp(M_icode_i);

    // popq/ret address through the stack pointer in valA, everything else through valE
    always_comb begin
        nextAcc.we    = (op == OP_WRITE);
        nextAcc.addr  = ((M_icode_i == ICODE_POPQ) || (M_icode_i == ICODE_RET)) ? M_valA_i : M_valE_i;
        nextAcc.wdata = M_valA_i;
    end

    // 65-bit end address so accesses near 2^64 cannot wrap into range
    assign endAddr  = {1'b0, nextAcc.addr} + 65'd8;
    assign inRange  = (endAddr <= 65'(MEM_BYTES));
    assign isMemOk  = (op != OP_NONE) && (M_stat_i == STAT_AOK);
    assign startAcc = (state == IDLE) && isMemOk && inRange;
    assign inReq    = (state == REQ);

    wait_timer #(
        .TMR_W  (TMR_W),
        .TIMEOUT(TIMEOUT)
    ) u_waitTimer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (startAcc),
        .enable (inReq),
        .expired(timerExpired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            memReq  <= 1'b0;
            acc     <= '0;
            valM    <= '0;
            statReg <= STAT_AOK;
        end else begin
            case (state)
                IDLE: begin
                    if (startAcc) begin
                        acc    <= nextAcc;
                        memReq <= 1'b1;
                        valM   <= '0;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    // a fault reported alongside an ack still fails the access
                    if (mem_err_i) begin
                        statReg <= STAT_ADR;
                        memReq  <= 1'b0;
                        state   <= DONE;
                    end else if (mem_ack_i) begin
                        if (!acc.we) begin
                            valM <= mem_rdata_i;
                        end
                        statReg <= STAT_AOK;
                        memReq  <= 1'b0;
                        state   <= DONE;
                    end else if (timerExpired) begin
                        statReg <= STAT_ADR;
                        memReq  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (!M_stall_i) begin
                        valM  <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy and status must react to the incoming instruction in the same IDLE cycle.
    always_comb begin
        m_busy_o = 1'b0;
        m_stat_o = M_stat_i;
        case (state)
            IDLE: begin
                if (isMemOk) begin
                    if (inRange) begin
                        m_busy_o = 1'b1;
                    end else begin
                        m_stat_o = STAT_ADR;
                    end
                end
            end
            REQ:     m_busy_o = 1'b1;
            DONE:    m_stat_o = statReg;
            default: m_busy_o = 1'b0;
        endcase
    end

    assign mem_req_o   = memReq;
    assign mem_we_o    = acc.we;
    assign mem_addr_o  = acc.addr;
    assign mem_wdata_o = acc.wdata;
    assign m_valM_o    = valM;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised bench for mem_access_ctrl: a per-instruction behavioural model sets expected
// outputs each cycle and a negedge process compares them against the DUT.
module tb_mem_access_ctrl;
    import y86_pkg::*;

    localparam int unsigned MEM_BYTES = 4096;
    localparam int unsigned TIMEOUT   = 255;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  M_icode_i;
    logic [2:0]  M_stat_i;
    logic [63:0] M_valE_i;
    logic [63:0] M_valA_i;
    logic        M_stall_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [63:0] mem_rdata_i;
    logic        mem_err_i;
    logic [63:0] m_valM_o;
    logic [2:0]  m_stat_o;
    logic        m_busy_o;

    mem_access_ctrl #(
        .MEM_BYTES(MEM_BYTES),
        .TIMEOUT  (TIMEOUT),
        .TMR_W    (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .M_icode_i  (M_icode_i),
        .M_stat_i   (M_stat_i),
        .M_valE_i   (M_valE_i),
        .M_valA_i   (M_valA_i),
        .M_stall_i  (M_stall_i),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .mem_err_i  (mem_err_i),
        .m_valM_o   (m_valM_o),
        .m_stat_o   (m_stat_o),
        .m_busy_o   (m_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int nChecks = 0;
    int nFails  = 0;
    int busyCnt = 0;
    int reqCnt  = 0;

    logic        chkEn   = 1'b0;
    logic        chkFull = 1'b0;
    logic        expReq, expWe, expBusy;
    logic [63:0] expAddr, expWdata, expValM;
    logic [2:0]  expStat;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every modelled output mid-cycle, away from the rising edge.
    always @(negedge clk_i) begin
        if (chkEn) begin
            check64("busy", 64'(m_busy_o), 64'(expBusy));
            check64("stat", 64'(m_stat_o), 64'(expStat));
            check64("req",  64'(mem_req_o), 64'(expReq));
            check64("valM", m_valM_o, expValM);
            if (expReq || chkFull) begin
                check64("we",   64'(mem_we_o), 64'(expWe));
                check64("addr", mem_addr_o, expAddr);
                if (expWe || chkFull) check64("wdata", mem_wdata_o, expWdata);
            end
            busyCnt += int'(m_busy_o);
            reqCnt  += int'(mem_req_o);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic noise();
        mem_ack_i   = 1'($urandom);
        mem_err_i   = 1'($urandom);
        mem_rdata_i = {$urandom, $urandom};
    endtask

    // One instruction through M: ackAt = REQ cycle index of the response (<0 means never).
    task automatic runInstr(input logic [3:0] icode, input logic [2:0] st, input logic [63:0] valE,
                            input logic [63:0] valA, input int ackAt, input bit errAt,
                            input int stallN, input logic [63:0] rdata);
        bit          isRd, isWr, legal, failed;
        logic [63:0] addr;
        int          nReq;
        isRd  = (icode == ICODE_MRMOVQ) || (icode == ICODE_POPQ) || (icode == ICODE_RET);
        isWr  = (icode == ICODE_RMMOVQ) || (icode == ICODE_PUSHQ) || (icode == ICODE_CALL);
        addr  = ((icode == ICODE_POPQ) || (icode == ICODE_RET)) ? valA : valE;
        legal = (addr <= 64'(MEM_BYTES - 8));
        M_icode_i = icode;
        M_stat_i  = st;
        M_valE_i  = valE;
        M_valA_i  = valA;
        M_stall_i = 1'b0;
        noise();
        expReq  = 1'b0;
        expValM = '0;
        expBusy = (isRd || isWr) && (st == STAT_AOK) && legal;
        expStat = ((isRd || isWr) && (st == STAT_AOK) && !legal) ? STAT_ADR : st;
        step();
        if (!expBusy) return;
        nReq = (ackAt >= 0 && ackAt <= int'(TIMEOUT)) ? ackAt + 1 : int'(TIMEOUT) + 1;
        for (int i = 0; i < nReq; i++) begin
            M_stall_i   = 1'b1;
            mem_ack_i   = (i == ackAt);
            mem_err_i   = errAt && (i == ackAt);
            mem_rdata_i = (i == ackAt) ? rdata : {$urandom, $urandom};
            expReq   = 1'b1;
            expWe    = isWr;
            expAddr  = addr;
            expWdata = valA;
            expBusy  = 1'b1;
            expStat  = st;
            expValM  = '0;
            step();
        end
        failed = errAt || (ackAt < 0) || (ackAt > int'(TIMEOUT));
        for (int i = 0; i <= stallN; i++) begin
            M_stall_i = (i < stallN);
            noise();
            expReq  = 1'b0;
            expBusy = 1'b0;
            expStat = failed ? STAT_ADR : STAT_AOK;
            expValM = (isRd && !failed) ? rdata : 64'd0;
            step();
        end
    endtask

    initial begin
        logic [3:0]  icode;
        logic [2:0]  st;
        logic [63:0] av;
        int          ackAt;

        // reset state, status passthrough while held in reset
        rst_i = 1'b1;
        M_icode_i = ICODE_NOP; M_stat_i = STAT_AOK; M_valE_i = '0; M_valA_i = '0; M_stall_i = 1'b0;
        noise();
        expReq = 0; expWe = 0; expBusy = 0; expAddr = '0; expWdata = '0; expValM = '0;
        expStat = STAT_AOK;
        chkFull = 1'b1;
        chkEn   = 1'b1;
        step();
        M_stat_i = STAT_INS; expStat = STAT_INS;
        step();
        rst_i = 1'b0;
        chkFull = 1'b0;

        // zero-wait load
        busyCnt = 0; reqCnt = 0;
        runInstr(ICODE_MRMOVQ, STAT_AOK, 64'h100, 64'h5, 0, 0, 0, 64'h1122334455667788);
        check64("t1_busy_cycles", 64'(busyCnt), 64'd2);
        check64("t1_req_cycles", 64'(reqCnt), 64'd1);

        // push with three wait states
        busyCnt = 0;
        runInstr(ICODE_PUSHQ, STAT_AOK, 64'h1F8, 64'hABCD, 3, 0, 0, 64'h0);
        check64("t2_busy_cycles", 64'(busyCnt), 64'd5);

        // out-of-range store and range boundaries
        busyCnt = 0; reqCnt = 0;
        runInstr(ICODE_RMMOVQ, STAT_AOK, 64'hFFC, 64'h1, 0, 0, 0, 64'h0);
        check64("t3_stat_adr", 64'(m_stat_o), 64'd3);
        check64("t3_busy_cycles", 64'(busyCnt), 64'd0);
        check64("t3_req_cycles", 64'(reqCnt), 64'd0);
        runInstr(ICODE_MRMOVQ, STAT_AOK, 64'hFF8, 64'h0, 1, 0, 0, 64'hCAFE);
        runInstr(ICODE_MRMOVQ, STAT_AOK, 64'hFF9, 64'h0, 1, 0, 0, 64'hCAFE);
        runInstr(ICODE_POPQ, STAT_AOK, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 64'h1);
        check64("wrap_stat_adr", 64'(m_stat_o), 64'd3);

        // ret whose memory never answers
        reqCnt = 0;
        runInstr(ICODE_RET, STAT_AOK, 64'h0, 64'h200, -1, 0, 0, 64'h0);
        check64("t4_req_cycles", 64'(reqCnt), 64'd256);
        check64("t4_req_low", 64'(mem_req_o), 64'd0);

        // err with ack, then non-memory instructions and a non-AOK load
        runInstr(ICODE_MRMOVQ, STAT_AOK, 64'h40, 64'h0, 2, 1, 0, 64'hDEAD_BEEF);
        busyCnt = 0;
        runInstr(ICODE_NOP, STAT_AOK, 64'h40, 64'h0, 0, 0, 0, 64'h0);
        runInstr(ICODE_OPQ, STAT_AOK, 64'h40, 64'h0, 0, 0, 0, 64'h0);
        runInstr(ICODE_MRMOVQ, STAT_INS, 64'h40, 64'h0, 0, 0, 0, 64'h0);
        check64("t5_busy_cycles", 64'(busyCnt), 64'd0);

        // reset pulse mid-REQ
        M_icode_i = ICODE_MRMOVQ; M_stat_i = STAT_AOK; M_valE_i = 64'h80; M_stall_i = 1'b0;
        mem_ack_i = 1'b0; mem_err_i = 1'b0;
        expReq = 0; expBusy = 1; expStat = STAT_AOK; expValM = '0;
        step();
        expReq = 1; expWe = 0; expAddr = 64'h80;
        step();
        step();
        chkEn = 1'b0;
        M_icode_i = ICODE_NOP;
        rst_i = 1'b1;
        #1;
        check64("t6_req_drop", 64'(mem_req_o), 64'd0);
        check64("t6_busy_idle", 64'(m_busy_o), 64'd0);
        step();
        rst_i = 1'b0;
        chkEn = 1'b1;

        // stalled DONE holds the loaded value
        runInstr(ICODE_MRMOVQ, STAT_AOK, 64'h300, 64'h0, 1, 0, 3, 64'h0123_4567_89AB_CDEF);

        // randomised instruction stream
        for (int n = 0; n < 150; n++) begin
            icode = 4'($urandom_range(0, 15));
            st    = ($urandom_range(0, 3) != 0) ? STAT_AOK : 3'($urandom_range(2, 4));
            case ($urandom_range(0, 3))
                0:       av = 64'($urandom_range(0, MEM_BYTES - 8));
                1:       av = 64'($urandom_range(MEM_BYTES - 16, MEM_BYTES + 4));
                2:       av = {$urandom, $urandom};
                default: av = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15));
            endcase
            ackAt = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 5));
            if (($urandom_range(0, 1) == 0))
                runInstr(icode, st, av, {$urandom, $urandom}, ackAt, ($urandom_range(0, 7) == 0),
                         int'($urandom_range(0, 2)), {$urandom, $urandom});
            else
                runInstr(icode, st, {$urandom, $urandom}, av, ackAt, ($urandom_range(0, 7) == 0),
                         int'($urandom_range(0, 2)), {$urandom, $urandom});
        end

        chkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
